// File: rtl/ksa_if.sv
// ksa_if: key-scheduling control plus S-memory port; master is the scheduler
interface ksa_if;
  logic        start_flag;
  logic [23:0] secret_key;
  logic        done_flag;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  modport master (input start_flag, secret_key, rddata, output done_flag, addr, wrdata, wren);
  modport slave  (output start_flag, secret_key, rddata, input done_flag, addr, wrdata, wren);
endinterface

// File: rtl/ksa_loop.sv
// ksa_loop: RC4 key-scheduling pass over an externally initialised 256-byte S memory
module ksa_loop #(
  parameter int KEY_LENGTH = 3,
  parameter int READ_WAIT  = 2
) (
  input  logic  clk,
  input  logic  reset,
  ksa_if.master bus
);
  typedef enum logic [3:0] {IDLE, READ_I, WAIT_I, SAVE_I, READ_J, WAIT_J, SAVE_J, WRITE_I, WRITE_J, NEXT, DONE} state_t;
  localparam int KW = KEY_LENGTH > 1 ? $clog2(KEY_LENGTH) : 1;
  state_t        state;
  logic [7:0]    i, j, data_i, data_j, cnt, addr_q, wrdata_q;
  logic [KW-1:0] kidx;
  logic          done_q, wren_q;
  logic [23:0]   key_sh;
  logic [7:0]    key_byte;
  assign key_sh   = bus.secret_key << {kidx, 3'b000};
  assign key_byte = key_sh[8*KEY_LENGTH-1 -: 8];
  assign bus.done_flag = done_q;
  assign bus.addr      = addr_q;
  assign bus.wrdata    = wrdata_q;
  assign bus.wren      = wren_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      kidx     <= '0;
      cnt      <= '0;
      data_i   <= '0;
      data_j   <= '0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          i    <= '0;
          j    <= '0;
          kidx <= '0;
          if (bus.start_flag) state <= READ_I;
        end
        READ_I: begin
          addr_q <= i;
          wren_q <= 1'b0;
          state  <= WAIT_I;
        end
        WAIT_I: begin
          cnt   <= cnt == 8'(READ_WAIT - 1) ? '0 : cnt + 8'd1;
          state <= cnt == 8'(READ_WAIT - 1) ? SAVE_I : WAIT_I;
        end
        SAVE_I: begin
          data_i <= bus.rddata;
          j      <= j + bus.rddata + key_byte;
          state  <= READ_J;
        end
        READ_J: begin
          addr_q <= j;
          state  <= WAIT_J;
        end
        WAIT_J: begin
          cnt   <= cnt == 8'(READ_WAIT - 1) ? '0 : cnt + 8'd1;
          state <= cnt == 8'(READ_WAIT - 1) ? SAVE_J : WAIT_J;
        end
        SAVE_J: begin
          data_j <= bus.rddata;
          state  <= WRITE_I;
        end
        WRITE_I: begin
          wren_q   <= 1'b1;
          addr_q   <= j;
          wrdata_q <= data_i;
          state    <= WRITE_J;
        end
        WRITE_J: begin
          wren_q   <= 1'b1;
          addr_q   <= i;
          wrdata_q <= data_j;
          state    <= NEXT;
        end
        NEXT: begin
          wren_q <= 1'b0;
          if (i == 8'hff) begin
            done_q <= 1'b1;
            addr_q <= '0;
            state  <= DONE;
          end else begin
            i     <= i + 8'd1;
            kidx  <= kidx == KW'(KEY_LENGTH - 1) ? '0 : kidx + 1'b1;
            state <= READ_I;
          end
        end
        DONE: begin
          wren_q <= 1'b0;
          addr_q <= '0;
          if (!bus.start_flag) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_loop.sv
// tb_ksa_loop: randomized KSA runs against a software RC4 key-schedule model
module tb_ksa_loop;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] init_mem [256];
  logic [15:0] wq [$];
  int wren_cnt = 0;
  int bad_wren = 0;
  int checks = 0;
  int errors = 0;
  ksa_if bus ();
  ksa_loop dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
      wq.push_back({bus.addr, bus.wrdata});
      wren_cnt <= wren_cnt + 1;
      if (bus.done_flag) bad_wren <= bad_wren + 1;
    end
    bus.rddata <= mem[bus.addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic ksa_model(input logic [7:0] s_in [256], input logic [23:0] key,
                           output logic [7:0] s [256], output logic [15:0] w [512]);
    int jj;
    logic [7:0] t;
    s = s_in;
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      jj = (jj + int'(s[ii]) + int'((key >> (8 * (2 - ii % 3))) & 24'hff)) % 256;
      w[2*ii]   = {8'(jj), s[ii]};
      w[2*ii+1] = {8'(ii), s[jj]};
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
    end
  endtask
  task automatic run(input logic [23:0] key, input bit toggle);
    logic [7:0] exp_s [256];
    logic [15:0] exp_w [512];
    int n, base_w, base_q, bad;
    ksa_model(init_mem, key, exp_s, exp_w);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    bus.secret_key = key;
    bus.start_flag = 1'b1;
    base_w = wren_cnt;
    base_q = wq.size();
    @(posedge clk); #1;
    n = 0;
    while (!bus.done_flag && n < 4000) begin
      if (toggle) bus.start_flag = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 2816);
    check("wren_cycles", wren_cnt - base_w, 512);
    check("done_addr", {31'd0, bus.wren} | 32'(bus.addr), 0);
    bad = 0;
    for (int k = 0; k < 512; k++)
      if (base_q + k >= wq.size() || wq[base_q + k] !== exp_w[k]) bad++;
    check("write_seq", bad, 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
    check("final_s", bad, 0);
  endtask
  task automatic drop_start;
    bus.start_flag = 1'b0;
    @(posedge clk); #1;
    check("done_clear", bus.done_flag, 0);
  endtask
  task automatic identity;
    for (int k = 0; k < 256; k++) init_mem[k] = 8'(k);
  endtask
  initial begin
    int w0;
    logic [7:0] t;
    bus.start_flag = 1'b0;
    bus.secret_key = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    #12;
    check("rst_done", bus.done_flag, 0);
    check("rst_wren", bus.wren, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wrdata", bus.wrdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    identity();
    run(24'h000000, 1'b0);
    check("v2_w0", wq[0], 16'h0000);
    check("v2_w1", wq[1], 16'h0000);
    check("v2_w2", wq[2], 16'h0101);
    check("v2_w3", wq[3], 16'h0101);
    check("v2_w4", wq[4], 16'h0302);
    check("v2_w5", wq[5], 16'h0203);
    w0 = wren_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", bus.done_flag, 1);
    check("hold_nowrite", wren_cnt - w0, 0);
    drop_start();
    run(24'h000249, 1'b0);
    drop_start();
    run(24'h000249, 1'b1);
    drop_start();
    identity();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    bus.start_flag = 1'b1;
    @(posedge clk); #1;
    bus.start_flag = 1'b0;
    w0 = wren_cnt;
    repeat (63) @(posedge clk);
    #1;
    check("pre_rst_writes", wren_cnt - w0, 10);
    reset = 1'b0;
    #1;
    check("abort_wren", bus.wren, 0);
    check("abort_done", bus.done_flag, 0);
    check("abort_addr", bus.addr, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_nowrite", wren_cnt - w0, 10);
    check("abort_idle", bus.done_flag, 0);
    for (int r = 0; r < 3; r++) begin
      identity();
      for (int k = 255; k > 0; k--) begin
        int m;
        m = $urandom_range(0, k);
        t = init_mem[k]; init_mem[k] = init_mem[m]; init_mem[m] = t;
      end
      run(24'($urandom), 1'b1);
      drop_start();
    end
    check("wren_total", wren_cnt, 512 * 6 + 10);
    check("wren_in_done", bad_wren, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ksa_loop.md
KSA_LOOP -- requirements
Module: ksa_loop

Interface
REQ-001 Parameter KEY_LENGTH, default 3, number of secret-key bytes used cyclically.
REQ-002 Parameter READ_WAIT, default 2, idle cycles between driving a read address and sampling rddata.
REQ-003 clk  input  1  clock, all state updated on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start_flag  input  1  request to run key scheduling; sampled only in IDLE.
REQ-006 secret_key  input  24  key; key[0]=bits 23:16, key[1]=15:8, key[2]=7:0; held stable while running.
REQ-007 done_flag  output  1  high when the S-array schedule is complete.
REQ-008 addr  output  8  S-memory address, read and write.
REQ-009 rddata  input  8  S-memory read data.
REQ-010 wrdata  output  8  S-memory write data.
REQ-011 wren  output  1  S-memory write enable, active-high.

Function
REQ-012 The block SHALL implement the RC4 KSA over a 256-byte S memory pre-initialised by the caller: j=0; for i=0..255: j=(j+S[i]+key[i mod KEY_LENGTH]) mod 256; swap S[i], S[j].
REQ-013 All outputs SHALL be registered.
REQ-014 States SHALL be: IDLE, READ_I, WAIT_I, SAVE_I, READ_J, WAIT_J, SAVE_J, WRITE_I, WRITE_J, NEXT, DONE.
REQ-015 IDLE: i=0, j=0, key index=0; start_flag=1 -> READ_I; otherwise remain.
REQ-016 READ_I: addr<=i, wren<=0 -> WAIT_I.
REQ-017 WAIT_I: hold for READ_WAIT cycles -> SAVE_I.
REQ-018 SAVE_I: data_i<=rddata; j<=(j+rddata+key[kidx]) mod 256, 8-bit wrap -> READ_J.
REQ-019 READ_J: addr<=j -> WAIT_J (READ_WAIT cycles) -> SAVE_J: data_j<=rddata -> WRITE_I.
REQ-020 WRITE_I: wren<=1, addr<=j, wrdata<=data_i -> WRITE_J.
REQ-021 WRITE_J: wren<=1, addr<=i, wrdata<=data_j -> NEXT.
REQ-022 NEXT: wren<=0; if i==255 -> DONE; else i<=i+1, kidx<=(kidx==KEY_LENGTH-1)?0:kidx+1 -> READ_I.
REQ-023 Key index SHALL be a wrapping counter; no divider/modulo operator on i.
REQ-024 With READ_WAIT=2, each iteration SHALL take exactly 11 cycles; done_flag SHALL rise 2816 clocks after the edge that leaves IDLE.
REQ-025 wren SHALL be high for exactly two consecutive cycles per iteration (addr j then addr i), and 512 cycles per run.
REQ-026 i==j: both writes target the same address; final contents SHALL equal the original S[i].
REQ-027 DONE: done_flag=1, wren=0, addr=0; remain while start_flag=1; start_flag=0 -> IDLE with done_flag<=0.
REQ-028 start_flag changes outside IDLE/DONE SHALL be ignored.
REQ-029 The block SHALL not read or write S in IDLE or DONE, so a downstream PRGA stage may own the memory after done_flag.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, i=0, j=0, kidx=0, done_flag=0, wren=0, addr=0, wrdata=0.
REQ-031 Reset mid-run SHALL abort without further writes; S contents are then undefined and must be re-initialised by the caller.
REQ-032 After reset release, a new run SHALL require start_flag=1 in IDLE.

Verification
VER-001 Assert reset mid-WRITE_I -> wren=0, done_flag=0, state IDLE in same cycle, no further writes.
VER-002 S=identity, key=0x000000 -> iteration 0 writes addr0<=0 twice; iteration 1 writes addr1<=1 twice; iteration 2 writes addr3<=2 then addr2<=3.
VER-003 S=identity, key=0x000249 -> final S matches software RC4 KSA model byte-for-byte; done_flag at 2816 clocks after start.
VER-004 Count wren-high cycles over full run -> exactly 512; no wren in IDLE/DONE.
VER-005 Hold start_flag=1 after done -> stays in DONE, no restart; drop start_flag -> done_flag=0 next cycle; reassert -> second run begins.
VER-006 Toggle start_flag during run -> timing and final S unchanged versus VER-003.
